fetch_branch_predictor: RTL and testbench

//  Fetch-stage dynamic branch predictor: direct-mapped BTB plus 2-bit saturating counters.

---
 rtl/fetch_branch_predictor.sv | 143 ++++++++++++++
 tb/tb_fetch_branch_predictor.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/fetch_branch_predictor.sv
// Fetch-stage branch predictor: direct-mapped BTB with 2-bit saturating counters,
// trained from decode-stage resolution, plus branch/mispredict performance counters.
module fetch_branch_predictor #(
  parameter int IDX_BITS = 6,
  parameter int TAG_BITS = 8,
  parameter int XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic [XLEN-1:0] pc_f,
  output logic            pred_taken_f,
  output logic [XLEN-1:0] pred_target_f,
  input  logic            upd_en,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_uncond,
  input  logic            upd_pred_taken,
  output logic [31:0]     branch_cnt,
  output logic [31:0]     mispred_cnt
);

  localparam int              ENTRIES = 1 << IDX_BITS;
  localparam logic [XLEN-1:0] PC_INC  = {{(XLEN-3){1'b0}}, 3'b100};
  localparam logic [31:0]     CNT_MAX = {32{1'b1}};

  logic                valid_q  [ENTRIES];
  logic                valid_d  [ENTRIES];
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [TAG_BITS-1:0] tag_d    [ENTRIES];
  logic [XLEN-1:0]     target_q [ENTRIES];
  logic [XLEN-1:0]     target_d [ENTRIES];
  logic [1:0]          ctr_q    [ENTRIES];
  logic [1:0]          ctr_d    [ENTRIES];
  logic [31:0]         branch_cnt_q, branch_cnt_d;
  logic [31:0]         mispred_cnt_q, mispred_cnt_d;

  logic [IDX_BITS-1:0] lk_idx, upd_idx;
  logic [TAG_BITS-1:0] lk_tag, upd_tag;
  logic                lk_hit, upd_hit, eff_taken;
  logic                unused_upd_pc;

  // Uncond jumps pin the counter at strongly-taken; otherwise saturating +/-1.
  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken,
                                          input logic uncond);
    if (uncond)
      return 2'b11;
    else if (taken)
      return (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
    else
      return (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
  endfunction

  assign lk_idx        = pc_f[IDX_BITS+1:2];
  assign lk_tag        = pc_f[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
  assign upd_idx       = upd_pc[IDX_BITS+1:2];
  assign upd_tag       = upd_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
  assign unused_upd_pc = ^{upd_pc[XLEN-1:IDX_BITS+TAG_BITS+2], upd_pc[1:0]};
  assign eff_taken     = upd_taken | upd_uncond;
  assign upd_hit       = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  // Lookup reads the pre-update table; no bypass from a same-cycle update.
  always_comb begin
    lk_hit        = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    pred_taken_f  = lk_hit & ctr_q[lk_idx][1];
    if (pred_taken_f)
      pred_target_f = target_q[lk_idx];
    else
      pred_target_f = pc_f + PC_INC;
  end

  // Table next-state: clear overrides any same-cycle training.
  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    if (clear) begin
      for (int i = 0; i < ENTRIES; i++) valid_d[i] = 1'b0;
    end else if (upd_en) begin
      if (upd_hit) begin
        ctr_d[upd_idx] = ctr_next(ctr_q[upd_idx], eff_taken, upd_uncond);
        if (eff_taken)
          target_d[upd_idx] = upd_target;
        else
          target_d[upd_idx] = target_q[upd_idx];
      end else if (eff_taken) begin
        valid_d[upd_idx]  = 1'b1;
        tag_d[upd_idx]    = upd_tag;
        target_d[upd_idx] = upd_target;
        ctr_d[upd_idx]    = upd_uncond ? 2'b11 : 2'b10;
      end else begin
        valid_d[upd_idx] = valid_q[upd_idx];
      end
    end else begin
      valid_d = valid_q;
    end
  end

  // Performance counters saturate instead of wrapping.
  always_comb begin
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (upd_en) begin
      if (branch_cnt_q != CNT_MAX)
        branch_cnt_d = branch_cnt_q + 32'd1;
      else
        branch_cnt_d = branch_cnt_q;
      if ((upd_pred_taken != eff_taken) && (mispred_cnt_q != CNT_MAX))
        mispred_cnt_d = mispred_cnt_q + 32'd1;
      else
        mispred_cnt_d = mispred_cnt_q;
    end else begin
      branch_cnt_d = branch_cnt_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= {TAG_BITS{1'b0}};
        target_q[i] <= {XLEN{1'b0}};
        ctr_q[i]    <= 2'b01;
      end
      branch_cnt_q  <= 32'd0;
      mispred_cnt_q <= 32'd0;
    end else begin
      valid_q       <= valid_d;
      tag_q         <= tag_d;
      target_q      <= target_d;
      ctr_q         <= ctr_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign branch_cnt  = branch_cnt_q;
  assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_fetch_branch_predictor.sv
// Directed table-driven bench for fetch_branch_predictor; each vector's expectations are
// the outputs seen during that cycle, i.e. before its own update lands.
module tb_fetch_branch_predictor;

  logic        clk = 1'b0;
  logic        rst_n, clear;
  logic [31:0] pc_f, pred_target_f, upd_pc, upd_target, branch_cnt, mispred_cnt;
  logic        pred_taken_f, upd_en, upd_taken, upd_uncond, upd_pred_taken;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        clr;
    logic [31:0] pc;
    logic        en;
    logic [31:0] upc;
    logic        tk;
    logic        unc;
    logic [31:0] tgt;
    logic        ptk;
    logic        e_tk;
    logic [31:0] e_tgt;
    logic [31:0] e_br;
    logic [31:0] e_mp;
  } vec_t;

  vec_t vecs[$];

  fetch_branch_predictor dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .pc_f(pc_f),
    .pred_taken_f(pred_taken_f), .pred_target_f(pred_target_f),
    .upd_en(upd_en), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_uncond(upd_uncond), .upd_pred_taken(upd_pred_taken),
    .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic clr, logic [31:0] pc, logic en, logic [31:0] upc,
                              logic tk, logic unc, logic [31:0] tgt, logic ptk,
                              logic e_tk, logic [31:0] e_tgt, logic [31:0] e_br,
                              logic [31:0] e_mp);
    vec_t v;
    v.clr = clr; v.pc = pc; v.en = en; v.upc = upc; v.tk = tk; v.unc = unc;
    v.tgt = tgt; v.ptk = ptk; v.e_tk = e_tk; v.e_tgt = e_tgt; v.e_br = e_br; v.e_mp = e_mp;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  task automatic idle();
    clear = 1'b0; upd_en = 1'b0; upd_pc = 32'h0; upd_taken = 1'b0;
    upd_target = 32'h0; upd_uncond = 1'b0; upd_pred_taken = 1'b0;
  endtask

  initial begin
    //         clr  pc      en  upc       tk  unc tgt     ptk  e_tk e_tgt    br  mp
    vecs.push_back(mk(0, 32'h100, 0, 32'h0,    0, 0, 32'h0,   0, 0, 32'h104, 0, 0));
    vecs.push_back(mk(0, 32'h100, 1, 32'h100,  1, 0, 32'h40,  0, 0, 32'h104, 0, 0));
    vecs.push_back(mk(0, 32'h100, 0, 32'h0,    0, 0, 32'h0,   0, 1, 32'h40,  1, 1));
    vecs.push_back(mk(0, 32'h100, 1, 32'h100,  0, 0, 32'h0,   1, 1, 32'h40,  1, 1));
    vecs.push_back(mk(0, 32'h100, 1, 32'h100,  0, 0, 32'h0,   0, 0, 32'h104, 2, 2));
    vecs.push_back(mk(0, 32'h100, 1, 32'h100,  0, 0, 32'h0,   0, 0, 32'h104, 3, 2));
    vecs.push_back(mk(0, 32'h100, 1, 32'h100,  1, 0, 32'h44,  0, 0, 32'h104, 4, 2));
    vecs.push_back(mk(0, 32'h100, 0, 32'h0,    0, 0, 32'h0,   0, 0, 32'h104, 5, 3));
    vecs.push_back(mk(0, 32'h100, 1, 32'h100,  1, 0, 32'h48,  0, 0, 32'h104, 5, 3));
    vecs.push_back(mk(0, 32'h100, 0, 32'h0,    0, 0, 32'h0,   0, 1, 32'h48,  6, 4));
    // jal allocates at index 0, evicting 0x100; then 0x300 aliases and evicts it
    vecs.push_back(mk(0, 32'h200, 1, 32'h200,  0, 1, 32'h800, 0, 0, 32'h204, 6, 4));
    vecs.push_back(mk(0, 32'h200, 0, 32'h0,    0, 0, 32'h0,   0, 1, 32'h800, 7, 5));
    vecs.push_back(mk(0, 32'h100, 0, 32'h0,    0, 0, 32'h0,   0, 0, 32'h104, 7, 5));
    vecs.push_back(mk(0, 32'h200, 1, 32'h300,  1, 0, 32'h900, 1, 1, 32'h800, 7, 5));
    vecs.push_back(mk(0, 32'h200, 0, 32'h0,    0, 0, 32'h0,   0, 0, 32'h204, 8, 5));
    vecs.push_back(mk(0, 32'h300, 0, 32'h0,    0, 0, 32'h0,   0, 1, 32'h900, 8, 5));
    // same-cycle lookup and update on one index: old prediction, then new
    vecs.push_back(mk(0, 32'h300, 1, 32'h300,  0, 0, 32'h0,   1, 1, 32'h900, 8, 5));
    vecs.push_back(mk(0, 32'h300, 0, 32'h0,    0, 0, 32'h0,   0, 0, 32'h304, 9, 6));
    vecs.push_back(mk(0, 32'h304, 1, 32'h300,  0, 1, 32'h910, 0, 0, 32'h308, 9, 6));
    vecs.push_back(mk(0, 32'h300, 0, 32'h0,    0, 0, 32'h0,   0, 1, 32'h910, 10, 7));
    vecs.push_back(mk(0, 32'h300, 1, 32'h1004, 1, 0, 32'hABC, 0, 1, 32'h910, 10, 7));
    vecs.push_back(mk(0, 32'h1004, 0, 32'h0,   0, 0, 32'h0,   0, 1, 32'hABC, 11, 8));
    vecs.push_back(mk(0, 32'h2004, 0, 32'h0,   0, 0, 32'h0,   0, 0, 32'h2008, 11, 8));
    vecs.push_back(mk(0, 32'h1006, 0, 32'h0,   0, 0, 32'h0,   0, 1, 32'hABC, 11, 8));
    // clear with a same-cycle update: table ends invalid, counters still count
    vecs.push_back(mk(1, 32'h1004, 1, 32'h1004, 1, 0, 32'h111, 1, 1, 32'hABC, 11, 8));
    vecs.push_back(mk(0, 32'h1004, 0, 32'h0,   0, 0, 32'h0,   0, 0, 32'h1008, 12, 8));
    vecs.push_back(mk(0, 32'h300, 0, 32'h0,    0, 0, 32'h0,   0, 0, 32'h304, 12, 8));
    vecs.push_back(mk(0, 32'h500, 1, 32'h500,  0, 0, 32'h0,   1, 0, 32'h504, 12, 8));
    vecs.push_back(mk(0, 32'h500, 0, 32'h0,    0, 0, 32'h0,   0, 0, 32'h504, 13, 9));

    idle();
    rst_n = 1'b0;
    pc_f  = 32'h100;
    #2;
    chk("reset_pred_taken", {31'd0, pred_taken_f}, 32'd0);
    chk("reset_pred_target", pred_target_f, 32'h104);
    chk("reset_branch_cnt", branch_cnt, 32'd0);
    chk("reset_mispred_cnt", mispred_cnt, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      clear = vecs[i].clr; pc_f = vecs[i].pc; upd_en = vecs[i].en; upd_pc = vecs[i].upc;
      upd_taken = vecs[i].tk; upd_uncond = vecs[i].unc; upd_target = vecs[i].tgt;
      upd_pred_taken = vecs[i].ptk;
      #1;
      chk($sformatf("v%0d_pred_taken", i), {31'd0, pred_taken_f}, {31'd0, vecs[i].e_tk});
      chk($sformatf("v%0d_pred_target", i), pred_target_f, vecs[i].e_tgt);
      chk($sformatf("v%0d_branch_cnt", i), branch_cnt, vecs[i].e_br);
      chk($sformatf("v%0d_mispred_cnt", i), mispred_cnt, vecs[i].e_mp);
    end

    // Train an entry, then assert reset asynchronously in the middle of an update.
    @(negedge clk);
    idle();
    pc_f = 32'h1004; upd_en = 1'b1; upd_pc = 32'h1004; upd_taken = 1'b1; upd_target = 32'h77;
    @(negedge clk);
    idle();
    #1;
    chk("train_pred_taken", {31'd0, pred_taken_f}, 32'd1);
    chk("train_pred_target", pred_target_f, 32'h77);
    chk("train_branch_cnt", branch_cnt, 32'd14);
    @(negedge clk);
    upd_en = 1'b1; upd_pc = 32'h1004; upd_taken = 1'b1; upd_target = 32'h99;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_pred_taken", {31'd0, pred_taken_f}, 32'd0);
    chk("async_rst_pred_target", pred_target_f, 32'h1008);
    chk("async_rst_branch_cnt", branch_cnt, 32'd0);
    chk("async_rst_mispred_cnt", mispred_cnt, 32'd0);
    @(negedge clk);
    idle();
    rst_n = 1'b1;
    #1;
    chk("post_rst_pred_taken", {31'd0, pred_taken_f}, 32'd0);
    chk("post_rst_branch_cnt", branch_cnt, 32'd0);
    @(negedge clk);
    #1;
    chk("post_rst_idle_pred_taken", {31'd0, pred_taken_f}, 32'd0);
    chk("post_rst_idle_mispred_cnt", mispred_cnt, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
